// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port, word-wide data memory between the core load/store
//   port (r0) and the DMA/debug port (r1). Grants alternate round-robin, and
//   byte/halfword stores are turned into a read-modify-write because the
//   memory only writes whole words.
//
// Ports
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   rK_req/we/size/addr/wdata  request level and its fields (held while req)
//   rK_gnt                 pulse: the request has been latched (ACCESS cycle)
//   rK_done / rK_err       pulse: access finished; err = misaligned, no write
//   rK_rdata               zero-extended load data, held until the next done
//   mem_we/addr/din        to the memory MemWrite/addr/din pins
//   mem_dout               combinational read data from the memory
module dmem_arbiter #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [1:0]        r0_size,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic              r0_err,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [1:0]        r1_size,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic              r1_err,
  output logic [31:0]       r1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state, next_state;

  // Latched request (captured on the IDLE -> ACCESS edge).
  logic              owner_p0;
  logic              we_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  // Holds wdata during ACCESS, then the merged word during WRITE.
  logic [31:0]       din_p0;
  logic              last;

  logic       avail0, avail1, any_req, winner;
  logic [1:0] offs;
  logic       acc_err, sub_word, finish;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane);
    return (word >> {lane, 3'b000}) & lane_mask(size);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    mask = lane_mask(size);
    return (word & ~(mask << {lane, 3'b000})) | ((data & mask) << {lane, 3'b000});
  endfunction

  // A port whose done is showing this cycle sits out arbitration, which is
  // what forces strict interleave when both ports hold req.
  assign avail0  = r0_req & ~r0_done;
  assign avail1  = r1_req & ~r1_done;
  assign any_req = avail0 | avail1;
  // Prefer the port that did not win last; otherwise whoever is asking.
  assign winner  = last ? ~avail0 : avail1;

  assign offs     = addr_p0[1:0];
  assign acc_err  = misaligned(size_p0, offs);
  assign sub_word = ~size_p0[1];

  assign r0_gnt   = (state == ACCESS) & ~owner_p0;
  assign r1_gnt   = (state == ACCESS) &  owner_p0;
  assign mem_addr = {addr_p0[ADDR_W-1:2], 2'b00};
  assign mem_din  = din_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // mem_we is decoded from state, so an asynchronous reset kills it at once.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) next_state = ACCESS;
      end
      ACCESS: begin
        if (acc_err) begin
          next_state = IDLE;
          finish     = 1'b1;
        end else if (we_p0 && sub_word) begin
          next_state = WRITE;
        end else begin
          next_state = IDLE;
          finish     = 1'b1;
          mem_we     = we_p0;
        end
      end
      WRITE: begin
        mem_we     = 1'b1;
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last     <= 1'b1;
      owner_p0 <= 1'b0;
      we_p0    <= 1'b0;
      size_p0  <= 2'b00;
      addr_p0  <= '0;
      din_p0   <= '0;
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_done <= finish & ~owner_p0;
      r1_done <= finish &  owner_p0;
      r0_err  <= finish & ~owner_p0 & acc_err;
      r1_err  <= finish &  owner_p0 & acc_err;

      // IDLE -> ACCESS: capture the winner
      if (state == IDLE && any_req) begin
        owner_p0 <= winner;
        last     <= winner;
        we_p0    <= winner ? r1_we    : r0_we;
        size_p0  <= winner ? r1_size  : r0_size;
        addr_p0  <= winner ? r1_addr  : r0_addr;
        din_p0   <= winner ? r1_wdata : r0_wdata;
      end

      // ACCESS -> WRITE / IDLE: merge sub-word store or return load data
      if (state == ACCESS && !acc_err) begin
        if (we_p0 && sub_word) begin
          din_p0 <= lane_merge(mem_dout, din_p0, size_p0, offs);
        end else if (!we_p0) begin
          if (owner_p0) r1_rdata <= lane_extract(mem_dout, size_p0, offs);
          else          r0_rdata <= lane_extract(mem_dout, size_p0, offs);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int ADDR_W = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  logic              req_v   [2];
  logic              we_v    [2];
  logic [1:0]        size_v  [2];
  logic [ADDR_W-1:0] addr_v  [2];
  logic [31:0]       wdata_v [2];

  logic r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err, mem_we;
  logic [31:0] r0_rdata, r1_rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req(req_v[0]), .r0_we(we_v[0]), .r0_size(size_v[0]), .r0_addr(addr_v[0]),
    .r0_wdata(wdata_v[0]), .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err),
    .r0_rdata(r0_rdata),
    .r1_req(req_v[1]), .r1_we(we_v[1]), .r1_size(size_v[1]), .r1_addr(addr_v[1]),
    .r1_wdata(wdata_v[1]), .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err),
    .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-wide memory seen by the DUT, and a byte-addressed reference image.
  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];
  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_din;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
    logic        has_st;
    int          st_addr;
    int          st_nb;
    logic [31:0] st_data;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [31:0] last_rd [2];
  int          gnt_cyc [2];
  int          gnt_order[$];
  logic        wr_next = 1'b0;
  logic [31:0] wr_next_din, wr_next_addr;
  logic        cyc_we_exp;
  logic [31:0] cyc_din_exp, cyc_addr_exp;

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] val);
    mem[w] = val;
    for (int i = 0; i < 4; i++) ref_mem[4*w+i] = val[8*i +: 8];
  endtask

  // Expected outcome computed from the access rules on a byte-addressed image.
  task automatic on_grant(input int k);
    exp_t e;
    int a, nb;
    logic [1:0] s;
    logic mis;
    logic [31:0] w;
    a  = int'(addr_v[k][9:0]);
    s  = size_v[k];
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    mis = ((nb == 2) && (a % 2 != 0)) || ((nb == 4) && (a % 4 != 0));
    e = '{default: '0};
    e.lat = 1;
    if (mis) begin
      e.err = 1'b1;
      e.rdata = last_rd[k];
      e.chk_rd = 1'b1;
    end else if (!we_v[k]) begin
      e.rdata = 32'h0;
      for (int i = 0; i < nb; i++) e.rdata = e.rdata | (32'(ref_mem[a+i]) << (8*i));
      last_rd[k] = e.rdata;
      e.chk_rd = 1'b1;
    end else begin
      e.has_st = 1'b1;
      e.st_addr = a;
      e.st_nb = nb;
      e.st_data = wdata_v[k];
      w = 32'h0;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] b;
        int ba;
        ba = (a & ~3) + i;
        b = ref_mem[ba];
        if (ba >= a && ba < a + nb) b = wdata_v[k][8*(ba-a) +: 8];
        w = w | (32'(b) << (8*i));
      end
      if (nb == 4) begin
        cyc_we_exp = 1'b1;
        cyc_din_exp = w;
        cyc_addr_exp = 32'(a & ~3);
      end else begin
        e.lat = 2;
        wr_next = 1'b1;
        wr_next_din = w;
        wr_next_addr = 32'(a & ~3);
      end
    end
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    gnt_cyc[k] = cyc;
    gnt_order.push_back(k);
  endtask

  task automatic on_done(input int k, input logic err, input logic [31:0] rdata);
    exp_t e;
    if ((k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
      check(k == 0 ? "r0_unexpected_done" : "r1_unexpected_done", 32'd1, 32'd0);
      return;
    end
    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check(k == 0 ? "r0_err" : "r1_err", 32'(err), 32'(e.err));
    check(k == 0 ? "r0_done_latency" : "r1_done_latency", 32'(cyc - gnt_cyc[k]), 32'(e.lat));
    if (e.chk_rd) check(k == 0 ? "r0_rdata" : "r1_rdata", rdata, e.rdata);
    if (e.has_st)
      for (int i = 0; i < e.st_nb; i++) ref_mem[e.st_addr+i] = e.st_data[8*i +: 8];
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q0.delete();
      exp_q1.delete();
      wr_next = 1'b0;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
    end else begin
      cyc_we_exp   = wr_next;
      cyc_din_exp  = wr_next_din;
      cyc_addr_exp = wr_next_addr;
      wr_next      = 1'b0;
      check("gnt_exclusive", 32'(r0_gnt & r1_gnt), 32'd0);
      if (r0_gnt) on_grant(0);
      if (r1_gnt) on_grant(1);
      check("mem_we", 32'(mem_we), 32'(cyc_we_exp));
      if (cyc_we_exp) begin
        check("mem_din", mem_din, cyc_din_exp);
        check("mem_addr", 32'(mem_addr), cyc_addr_exp);
      end
      if (r0_done) on_done(0, r0_err, r0_rdata);
      if (r1_done) on_done(1, r1_err, r1_rdata);
      check("err_without_done", 32'((r0_err & ~r0_done) | (r1_err & ~r1_done)), 32'd0);
    end
  end

  task automatic issue(input int k, input logic we, input logic [1:0] size, input int addr,
                       input logic [31:0] wdata, output int gnt_wait);
    bit ok;
    @(posedge clk); #1;
    we_v[k] = we; size_v[k] = size; addr_v[k] = ADDR_W'(addr); wdata_v[k] = wdata;
    req_v[k] = 1'b1;
    ok = 1'b0;
    gnt_wait = 0;
    while (gnt_wait < 50 && !ok) begin
      @(negedge clk);
      gnt_wait++;
      ok = (k == 0) ? r0_gnt : r1_gnt;
    end
    check("gnt_seen", 32'(ok), 32'd1);
    if (!ok) begin
      req_v[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_v[k] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 6 && !ok; n++) begin
      @(negedge clk);
      ok = (k == 0) ? r0_done : r1_done;
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},   32'({r1_gnt, r0_gnt}), 32'd0);
    check({tag, "_done"},  32'({r1_done, r0_done}), 32'd0);
    check({tag, "_err"},   32'({r1_err, r0_err}), 32'd0);
    check({tag, "_rdata0"}, r0_rdata, 32'h0);
    check({tag, "_rdata1"}, r1_rdata, 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_mem_din"}, mem_din, 32'h0);
  endtask

  task automatic driver(input int k);
    int gw;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
            $urandom, gw);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw;
    logic [31:0] saved;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; we_v[k] = 1'b0; size_v[k] = 2'b00; addr_v[k] = '0; wdata_v[k] = 32'h0;
    end
    for (int w = 0; w < 256; w++) set_word(w, $urandom);
    set_word(0, 32'h0000_0003);
    set_word(3, 32'hFFFF_FFB7);

    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    reset_n = 1'b1;

    // Word load, uncontended
    issue(0, 1'b0, 2'b10, 12, 32'h0, gw);
    check("load_gnt_cycle", 32'(gw), 32'd2);
    check("load_word12", r0_rdata, 32'hFFFF_FFB7);

    // Byte store by RMW, then read back
    issue(1, 1'b1, 2'b00, 13, 32'h0000_00AA, gw);
    check("byte_store_mem", mem[3], 32'hFFFF_AAB7);
    issue(0, 1'b0, 2'b10, 12, 32'h0, gw);
    check("load_after_byte_store", r0_rdata, 32'hFFFF_AAB7);

    // Half store and half load
    issue(0, 1'b1, 2'b01, 2, 32'h0000_1234, gw);
    check("half_store_mem", mem[0], 32'h1234_0003);
    issue(1, 1'b0, 2'b01, 2, 32'h0, gw);
    check("half_load", r1_rdata, 32'h0000_1234);

    // Misalignment
    saved = mem[1];
    issue(0, 1'b1, 2'b10, 6, 32'hDEAD_BEEF, gw);
    check("misaligned_store_mem", mem[1], saved);
    issue(1, 1'b0, 2'b01, 1, 32'h0, gw);
    check("misaligned_load_rdata", r1_rdata, 32'h0000_1234);

    // Reset in the middle of a read-modify-write
    saved = mem[5];
    @(posedge clk); #1;
    we_v[1] = 1'b1; size_v[1] = 2'b00; addr_v[1] = ADDR_W'(21); wdata_v[1] = 32'h55;
    req_v[1] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      ok = r1_gnt;
    end
    check("rmw_gnt_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    check("rmw_we_in_write", 32'(mem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_reset("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    check("rmw_target_unchanged", mem[5], saved);

    // Simultaneous requests after reset: r0 first, then r1
    gnt_order.delete();
    fork
      issue(0, 1'b0, 2'b10, 12, 32'h0, gw);
      begin
        int gw1;
        issue(1, 1'b0, 2'b10, 0, 32'h0, gw1);
      end
    join
    check("contention_first", 32'(gnt_order.size() > 0 ? gnt_order[0] : 9), 32'd0);
    check("contention_second", 32'(gnt_order.size() > 1 ? gnt_order[1] : 9), 32'd1);

    // Both ports hold req: strict alternation starting with r0 (r1 won last)
    gnt_order.delete();
    @(posedge clk); #1;
    we_v[0] = 1'b0; size_v[0] = 2'b10; addr_v[0] = ADDR_W'(8);
    we_v[1] = 1'b0; size_v[1] = 2'b00; addr_v[1] = ADDR_W'(17);
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    for (int n = 0; n < 60 && gnt_order.size() < 8; n++) @(negedge clk);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (6) @(posedge clk);
    check("hold_grant_count", 32'(gnt_order.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < gnt_order.size(); i++)
      check("hold_alternate", 32'(gnt_order[i]), 32'(i % 2));

    // Randomized traffic on both ports
    fork
      driver(0);
      driver(1);
    join
    repeat (6) @(posedge clk);

    for (int w = 0; w < 256; w++) check("mem_image", mem[w], ref_word(w));
    check("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port, word-wide data memory. It lets the core load/store port (r0) and the DMA/debug port (r1) share the memory. It also adds byte and halfword stores by read-modify-write, because the memory writes only whole words. It sits between the requesters and the memory's `MemWrite`/`addr`/`din`/`dout` pins.

## Interface
- `ADDR_W`, default 20: byte-address width, matching the memory `addr` port.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rK_req` in 1 (K=0,1): request level. `rK_we`, `rK_size`, `rK_addr` and `rK_wdata` must be held stable while it is high.
- `rK_we` in 1: 1 = store, 0 = load.
- `rK_size` in 2: 00 = byte, 01 = half, 10 = word. 11 is treated as word.
- `rK_addr` in ADDR_W: byte address.
- `rK_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rK_gnt` out 1: one-cycle pulse; the request was latched.
- `rK_done` out 1: one-cycle pulse; the access completed.
- `rK_err` out 1: valid with done; 1 = misaligned access, nothing written.
- `rK_rdata` out 32: load data, zero-extended and right-aligned. Valid with done and held until that port's next done.
- `mem_we` out 1: to memory `MemWrite`.
- `mem_addr` out ADDR_W: to memory `addr`. Always word-aligned: {addr[ADDR_W-1:2], 2'b00}.
- `mem_din` out 32: to memory `din`.
- `mem_dout` in 32: from memory `dout` (combinational read).

## Operation
- **States.** IDLE, ACCESS, WRITE.
- **IDLE.** Selects a winner among unmasked `req`s using round-robin.
  - The winner is the port other than `last`. If that port is not requesting, the requester wins.
  - On the clock edge, the winner's fields are latched, `last` is set to the winner, and the state goes to ACCESS.
  - No request: stay in IDLE.
- **Masking.** A port whose `done` is high in the current cycle is masked from arbitration that cycle.
- **Misalignment.** Half with addr[0]=1, or word with addr[1:0]≠0.
  - ACCESS goes to IDLE with `done=1`, `err=1` and `rdata` unchanged.
  - `mem_we` stays 0 throughout.
- **ACCESS, load.** Extracts from `mem_dout`:
  - byte lane addr[1:0], or half lane addr[1] (little-endian: lane 0 = bits [7:0]);
  - zero-extends the result, registers it into `rdata`, and goes to IDLE with `done`.
- **ACCESS, word store.** `mem_we=1`, `mem_din=wdata`; goes to IDLE with `done`.
- **ACCESS, byte/half store.** `mem_we=0`.
  - Registers the merged word: `mem_dout` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Goes to WRITE.
- **WRITE.** `mem_we=1`, `mem_din=merged`; goes to IDLE with `done`.
- **Memory outputs.**
  - `mem_we` is decoded from state and latched op, and is 0 in IDLE.
  - `mem_addr` and `mem_din` come from latched registers and hold their value in IDLE.
- **`err`.** Low whenever `done` is low.

## Timing
- **Reset values.**
  - state=IDLE, `last`=1 (so r0 wins the first tie).
  - All `gnt`/`done`/`err` = 0, `rdata` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0.
- **Reset during ACCESS or WRITE.**
  - `mem_we` drops immediately (asynchronous), so no partial write reaches memory.
  - The access is aborted and no `done` is issued.
- **Cycle numbering.** Cycle 0 is `req` high in IDLE.
  - Cycle 1: ACCESS, `gnt` high.
  - Load, word store, or error: cycle 2 has `done` high, and the FSM is back in IDLE able to accept the other port.
  - Byte/half store: cycle 2 is WRITE; cycle 3 has `done` high.
- **Memory write timing.** The write commits at the rising edge that ends the cycle in which `mem_we=1`. A load issued right after a store therefore sees the new data.
- **Throughput.**
  - A single port holding `req` continuously gets one access per 3 cycles (word) or 4 cycles (sub-word), because of the masked `done` cycle.
  - Two ports interleave strictly when both request.
- **Simultaneous requests** in IDLE: round-robin as above. Never both `gnt` in the same cycle.
- **`rK_req` dropping** after `gnt`: ignored. The latched access completes.

## Test plan
- **Reset, then a word load from r0.**
  - Memory model: word@0 = 0x00000003, word@12 = 0xFFFFFFB7.
  - r0 load word addr 12 → `gnt` at cycle 1, `done` at cycle 2, `rdata` = 0xFFFFFFB7, `err` = 0.
- **Byte store by RMW.**
  - r1 stores byte 0xAA at addr 13 → `mem_we` low in ACCESS and high only in WRITE with `mem_din` = 0xFFFFAAB7, `done` at cycle 3.
  - A following word load of 12 returns 0xFFFFAAB7.
- **Half store and half load.**
  - Store half 0x1234 at addr 2 over word@0 = 0x00000003 → memory = 0x12340003.
  - Half load from addr 2 → `rdata` = 0x00001234.
- **Contention.**
  - r0 and r1 raise `req` in the same cycle after reset → r0 granted first and r1 next.
  - Both held continuously → grants alternate r0, r1, r0, r1.
  - `gnt` is never high on both ports.
- **Misalignment.**
  - Word store at addr 6 → `done` and `err` at cycle 2, `mem_we` never 1, memory unchanged.
  - Half load at addr 1 → `err` = 1, `rdata` unchanged.
- **Reset mid-RMW.**
  - Assert `reset_n` low during WRITE → `mem_we` goes 0 before the next edge, target word unchanged, no `done`, and all outputs at reset values.
